// File: rtl/tea_arbiter.sv
// Round-robin arbiter/sequencer sharing one TEA engine among NREQ requesters, one block in flight.
// Optional busy watchdog enabled by defining TEA_ARB_WDOG_EN.
module tea_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_mode,
    input  logic [64*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [63:0]       eng_in,
    output logic              eng_mode,
    output logic              eng_write,
    input  logic [63:0]       eng_out,
    input  logic              eng_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [63:0]       rsp_data,
    output logic              rsp_err,
    input  logic              rsp_ready
);

    if (NREQ < 2 || NREQ > 16 || (2 ** IDW) < NREQ || TIMEOUT == 0 || TIMEOUT > 65535)
    begin : g_bad_cfg
        $error("tea_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [63:0]     data_q, data_d;
    logic            mode_q, mode_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [63:0]     rsp_data_q, rsp_data_d;
`ifdef TEA_ARB_WDOG_EN
    logic            rsp_err_q, rsp_err_d;
    logic [15:0]     wdog_q, wdog_d;
`endif

    // Round-robin search starting at ptr_q, wrapping modulo NREQ.
    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [IDW:0]    cand;
    logic [63:0]     sel_data;
    logic            sel_mode;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!win_found && req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_mode = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                sel_data = req_data[64*i +: 64];
                sel_mode = req_mode[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            data_q     <= '0;
            mode_q     <= 1'b0;
            id_q       <= '0;
            rsp_data_q <= '0;
`ifdef TEA_ARB_WDOG_EN
            rsp_err_q  <= 1'b0;
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            mode_q     <= mode_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
`ifdef TEA_ARB_WDOG_EN
            rsp_err_q  <= rsp_err_d;
            wdog_q     <= wdog_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        mode_d     = mode_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
`ifdef TEA_ARB_WDOG_EN
        rsp_err_d  = rsp_err_q;
        wdog_d     = wdog_q;
`endif
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    data_d  = sel_data;
                    mode_d  = sel_mode;
                    id_d    = win_idx;
                    ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StBusy;
`ifdef TEA_ARB_WDOG_EN
                wdog_d  = '0;
`endif
            end
            StBusy: begin
                // A completion in the same cycle as the timeout still wins.
                if (eng_ready) begin
                    rsp_data_d = eng_out;
`ifdef TEA_ARB_WDOG_EN
                    rsp_err_d  = 1'b0;
`endif
                    state_d    = StResp;
                end
`ifdef TEA_ARB_WDOG_EN
                else if (wdog_q == 16'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
`endif
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && win_found && !reset) begin
            req_ready[win_idx] = 1'b1;
        end
        eng_write = (state_q == StIssue);
        eng_in    = data_q;
        eng_mode  = mode_q;
        rsp_valid = (state_q == StResp);
        rsp_id    = id_q;
        rsp_data  = rsp_data_q;
`ifdef TEA_ARB_WDOG_EN
        rsp_err   = rsp_err_q;
`else
        rsp_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_tea_arbiter.sv
// Self-checking bench for tea_arbiter: engine model plus a transaction-level reference model.
// Watchdog scenario runs only when TEA_ARB_WDOG_EN is defined.
module tb_tea_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;
    localparam int ENG_LAT = 33;

    localparam int PH_IDLE  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_BUSY  = 2;
    localparam int PH_RESP  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid, req_mode, req_ready;
    logic [64*NREQ-1:0] req_data;
    logic [63:0]       eng_in, eng_out, rsp_data;
    logic              eng_mode, eng_write, eng_ready, rsp_valid, rsp_err, rsp_ready;
    logic [IDW-1:0]    rsp_id;

    tea_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .req_ready (req_ready),
        .eng_in    (eng_in),
        .eng_mode  (eng_mode),
        .eng_write (eng_write),
        .eng_out   (eng_out),
        .eng_ready (eng_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          phase = PH_IDLE;
    int          ptr_m = 0;
    logic [63:0] m_in;
    logic        m_mode;
    int          m_id;
    logic [63:0] m_rsp;
    logic        m_err;
    int          busy_cycles;
    int          grants[$];
    int          n_accepts = 0;
    int          n_writes  = 0;
    bit          just_reset = 1'b0;

    // Engine model
    int          eng_cnt = 0;
    logic [63:0] eng_res;
    bit          spur = 1'b0;
    bit          eng_en = 1'b1;

    function automatic int winner(input int p, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Engine drives at negedge, then the model checks this cycle and decides the next edge.
    always @(negedge clk) begin
        int          w;
        logic [NREQ-1:0] exp_rr;
        eng_ready = 1'b0;
        eng_out   = {$urandom, $urandom};
        if (spur) begin
            eng_ready = 1'b1;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0 && eng_en) begin
                eng_ready = 1'b1;
                eng_out   = eng_res;
            end
        end
        if (eng_write) begin
            eng_cnt = ENG_LAT;
            eng_res = eng_mode ? eng_in : ~eng_in;
            n_writes++;
        end

        if (reset) begin
            phase      = PH_IDLE;
            ptr_m      = 0;
            just_reset = 1'b1;
        end else begin
            if (just_reset) begin
                check_eq("rst_eng_in", eng_in, 64'd0);
                check_eq("rst_eng_mode", eng_mode, 0);
                check_eq("rst_rsp_data", rsp_data, 64'd0);
                check_eq("rst_rsp_id", rsp_id, 0);
                check_eq("rst_rsp_err", rsp_err, 0);
                just_reset = 1'b0;
            end
            w = winner(ptr_m, req_valid);
            exp_rr = (phase == PH_IDLE && w >= 0) ? (NREQ'(1) << w) : '0;
            check_eq("req_ready", req_ready, exp_rr);
            check_eq("eng_write", eng_write, phase == PH_ISSUE);
            if (phase == PH_ISSUE || phase == PH_BUSY) begin
                check_eq("eng_in", eng_in, m_in);
                check_eq("eng_mode", eng_mode, m_mode);
            end
            check_eq("rsp_valid", rsp_valid, phase == PH_RESP);
            if (phase == PH_RESP) begin
                check_eq("rsp_id", rsp_id, m_id);
                check_eq("rsp_data", rsp_data, m_rsp);
                check_eq("rsp_err", rsp_err, m_err);
            end
            case (phase)
                PH_IDLE: if (w >= 0) begin
                    m_in   = req_data[64*w +: 64];
                    m_mode = req_mode[w];
                    m_id   = w;
                    ptr_m  = (w + 1) % NREQ;
                    grants.push_back(w);
                    n_accepts++;
                    phase  = PH_ISSUE;
                end
                PH_ISSUE: begin
                    phase       = PH_BUSY;
                    busy_cycles = 0;
                end
                PH_BUSY: begin
                    busy_cycles++;
                    if (eng_ready) begin
                        m_rsp = m_mode ? m_in : ~m_in;
                        m_err = 1'b0;
                        phase = PH_RESP;
                    end
`ifdef TEA_ARB_WDOG_EN
                    else if (busy_cycles == TIMEOUT) begin
                        m_rsp = '0;
                        m_err = 1'b1;
                        phase = PH_RESP;
                    end
`endif
                end
                default: if (rsp_ready) phase = PH_IDLE;
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp();
        for (int k = 0; k < 200 && !rsp_valid; k++) cyc();
        check_eq("rsp_arrives", rsp_valid, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && phase != PH_IDLE; k++) cyc();
        check_eq("reach_idle", phase == PH_IDLE, 1);
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset     = 1'b1;
        cyc();
        reset     = 1'b0;
    endtask

    initial begin
        int wr0;
        reset     = 1'b1;
        req_valid = '0;
        req_mode  = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_eng_write", eng_write, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);

        // Single request from requester 2, encrypt
        wr0 = n_writes;
        req_data[128 +: 64] = 64'h0123456789ABCDEF;
        req_mode  = 4'b0000;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        cyc();
        req_valid = '0;
        wait_rsp();
        check_eq("single_id", rsp_id, 2);
        check_eq("single_data", rsp_data, 64'hFEDCBA9876543210);
        check_eq("single_err", rsp_err, 0);
        wait_idle();
        check_eq("single_writes", n_writes - wr0, 1);

        // All four continuously valid straight after reset
        do_reset();
        grants.delete();
        req_valid = 4'hF;
        for (int k = 0; k < 400 && grants.size() < 5; k++) begin
            req_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            req_mode = 4'($urandom);
            cyc();
        end
        req_valid = '0;
        check_eq("rr_count", grants.size(), 5);
        if (grants.size() >= 5) begin
            check_eq("rr_g0", grants[0], 0);
            check_eq("rr_g1", grants[1], 1);
            check_eq("rr_g2", grants[2], 2);
            check_eq("rr_g3", grants[3], 3);
            check_eq("rr_g4", grants[4], 0);
        end
        wait_idle();

        // Response back-pressure: ptr now 1, requester 1 wins, requester 0 waits
        rsp_ready = 1'b0;
        req_data[64 +: 64] = 64'hA5A50000FFFF1234;
        req_mode  = 4'b0010;
        req_valid = 4'b0010;
        cyc();
        req_valid = 4'b0001;
        wait_rsp();
        wr0 = n_writes;
        for (int k = 0; k < 10; k++) begin
            check_eq("hold_valid", rsp_valid, 1);
            check_eq("hold_data", rsp_data, 64'hA5A50000FFFF1234);
            check_eq("hold_id", rsp_id, 1);
            check_eq("hold_req_ready", req_ready, 0);
            cyc();
        end
        check_eq("hold_no_write", n_writes - wr0, 0);
        rsp_ready = 1'b1;
        cyc();
        check_eq("after_hold_ready", req_ready, 4'b0001);
        cyc();
        req_valid = '0;
        check_eq("after_hold_write", eng_write, 1);
        wait_rsp();
        wait_idle();

        // Spurious engine completion while idle
        spur = 1'b1;
        cyc();
        spur = 1'b0;
        repeat (3) begin
            cyc();
            check_eq("spur_rsp_valid", rsp_valid, 0);
            check_eq("spur_eng_write", eng_write, 0);
        end

        // Reset mid-BUSY; the engine keeps counting so its late pulse lands in IDLE
        req_valid = 4'b1000;
        cyc();
        req_valid = '0;
        repeat (10) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_eq("mid_req_ready", req_ready, 0);
        check_eq("mid_eng_write", eng_write, 0);
        check_eq("mid_eng_in", eng_in, 64'd0);
        check_eq("mid_eng_mode", eng_mode, 0);
        check_eq("mid_rsp_valid", rsp_valid, 0);
        check_eq("mid_rsp_id", rsp_id, 0);
        check_eq("mid_rsp_data", rsp_data, 64'd0);
        check_eq("mid_rsp_err", rsp_err, 0);
        repeat (30) begin
            cyc();
            check_eq("late_rsp_valid", rsp_valid, 0);
        end
        grants.delete();
        req_data[0 +: 64] = 64'h1122334455667788;
        req_mode  = 4'b0000;
        req_valid = 4'b1001;
        cyc();
        req_valid = '0;
        check_eq("fresh_grant", (grants.size() == 1) ? grants[0] : -1, 0);
        wait_rsp();
        check_eq("fresh_id", rsp_id, 0);
        check_eq("fresh_data", rsp_data, ~64'h1122334455667788);
        wait_idle();

`ifdef TEA_ARB_WDOG_EN
        // Engine never answers: watchdog completes the block with an error
        begin
            int lat;
            eng_en    = 1'b0;
            req_valid = 4'b0100;
            cyc();
            req_valid = '0;
            lat = 0;
            while (!rsp_valid && lat < 200) begin
                cyc();
                lat++;
            end
            check_eq("wdog_latency", lat, TIMEOUT + 1);
            check_eq("wdog_err", rsp_err, 1);
            check_eq("wdog_data", rsp_data, 64'd0);
            eng_en = 1'b1;
            wait_idle();
        end
`endif

        // Randomised traffic with random back-pressure and idle-time spurious pulses
        for (int k = 0; k < 3000; k++) begin
            req_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req_valid;
            req_mode  = 4'($urandom);
            req_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rsp_ready = ($urandom_range(0, 2) != 0);
            spur      = (phase != PH_BUSY) && ($urandom_range(0, 40) == 0);
            cyc();
        end
        spur      = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        check_eq("rand_progress", n_accepts > 30, 1);
        check_eq("writes_per_accept", n_writes, n_accepts);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tea_arbiter.md
# tea_arbiter

Round-robin arbiter and sequencer that shares one TEA encrypt/decrypt engine among `NREQ` requesters. It sits between requester ports and a single engine instance. It accepts one 64-bit block plus mode from the granted requester and pulses the engine's write strobe. It then waits for the engine's completion pulse and returns the result, tagged with the requester index, on a valid/ready response port. Only one block is in flight at a time.

## Interface
- `NREQ`, 4, number of requesters (2..16).
- `IDW`, 2, width of requester index; must satisfy 2^IDW >= NREQ.
- `TIMEOUT`, 64, watchdog limit in cycles; only used when `TEA_ARB_WDOG_EN` is defined.

- `clk` in 1 — clock; all logic on posedge.
- `reset` in 1 — reset, synchronous, active-high.
- `req_valid` in NREQ — requester i has a block pending.
- `req_mode` in NREQ — per requester: 0 = encrypt, 1 = decrypt.
- `req_data` in 64*NREQ — block for requester i in bits [64*i+63:64*i].
- `req_ready` out NREQ — one-hot grant/accept.
- `eng_in` out 64 — block to engine.
- `eng_mode` out 1 — mode to engine.
- `eng_write` out 1 — one-cycle write strobe to engine.
- `eng_out` in 64 — engine result.
- `eng_ready` in 1 — engine completion pulse, one cycle wide.
- `rsp_valid` out 1 — response available.
- `rsp_id` out IDW — index of the requester that owns the response.
- `rsp_data` out 64 — result block.
- `rsp_err` out 1 — watchdog error flag, valid with `rsp_valid`.
- `rsp_ready` in 1 — consumer accepts the response.

## Operation
- FSM states: IDLE, ISSUE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - Winner = first i with `req_valid[i]`, searching from `ptr` upward modulo NREQ.
  - `req_ready` = one-hot(winner), combinational. It is 0 if no request is valid.
  - On accept (valid & ready): latch data, mode and id; set `ptr` <= (winner+1) mod NREQ; go to ISSUE.
- ISSUE: `eng_write`=1 for exactly this cycle, with latched `eng_in`/`eng_mode`; go to BUSY.
- BUSY: hold `eng_in`/`eng_mode`.
  - On `eng_ready`=1: capture `eng_out` into `rsp_data`, set `rsp_err`=0, go to RESP.
- RESP: `rsp_valid`=1; `rsp_data`/`rsp_id`/`rsp_err` stable.
  - On `rsp_ready`=1: go to IDLE.
- `req_ready` is 0 in every state other than IDLE.
- `eng_ready` seen in IDLE, ISSUE or RESP is ignored. It raises no error and causes no state change.
- `ptr` is IDW bits wide. It wraps from NREQ-1 to 0; values >= NREQ are never produced.
- A requester dropping `req_valid` in IDLE before accept is legal; the winner is recomputed every cycle.
- The engine shares `reset`. Reset at any point aborts the in-flight block and discards its result.
- Reset values:
  - outputs: `req_ready`=0, `eng_write`=0, `eng_in`=0, `eng_mode`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0
  - internal: `ptr`=0, state IDLE.

## Timing
- Accept at edge N (IDLE→ISSUE).
- `eng_write` is high during cycle N+1.
- `eng_ready` sampled high at edge M → `rsp_valid` high from M+1.
- Response consumed at edge K → `req_ready` can assert in cycle K+1, and the next accept can occur at edge K+1.
- Minimum overhead beyond engine latency: 3 cycles per block (ISSUE, RESP, IDLE).
- With `rsp_ready` tied high, back-to-back requests cost engine latency + 3 cycles each.
- `eng_write` never asserts more than once per accepted block.

## Configuration
- `TEA_ARB_WDOG_EN` defined: a 16-bit cycle counter runs in BUSY, cleared on entry.
  - If it reaches `TIMEOUT` without `eng_ready`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - A late `eng_ready` after the timeout is ignored per the IDLE/RESP rule.
- Not defined: no counter; BUSY waits indefinitely; `rsp_err` tied to 0.

## Test plan
The bench engine model returns ~in for encrypt and in for decrypt. It pulses `eng_ready` 33 cycles after `eng_write`.
- Single request: req 2 with data 64'h0123456789ABCDEF, mode 0 → one `eng_write` pulse, then `rsp_valid` with `rsp_id`=2, `rsp_data`=64'hFEDCBA9876543210, `rsp_err`=0.
- All four requesters valid continuously after reset → grant order 0,1,2,3,0; each `rsp_id` matches its grant.
- `rsp_ready` held low for 10 cycles in RESP → `rsp_data` stable, `req_ready`=0, no new `eng_write`; the new accept occurs 1 cycle after `rsp_ready`=1.
- Reset asserted mid-BUSY → next cycle all outputs are 0; the late `eng_ready` is ignored; a fresh request to req 0 completes normally with `ptr` restarting at 0.
- Spurious `eng_ready` pulse in IDLE → no `rsp_valid`, state unchanged.
- With `TEA_ARB_WDOG_EN` and `TIMEOUT`=64, the engine never responds → `rsp_valid` with `rsp_err`=1 and `rsp_data`=0 once the counter reaches 64, i.e. at the cycle-count limit after BUSY entry.
